// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: derives the sample tick from mclk, steps the envelope once per tick
// and emits one scaled sample per tick toward the mixer.
module adsr_envelope #(
  parameter int unsigned MCLK_DIV = 256,
  parameter int unsigned LVL_BITS = 16
) (
  input  logic                mclk,
  input  logic                rst,
  input  logic                gate,
  input  logic [LVL_BITS-1:0] attack_step,
  input  logic [LVL_BITS-1:0] decay_step,
  input  logic [LVL_BITS-1:0] sustain_level,
  input  logic [LVL_BITS-1:0] release_step,
  input  logic [15:0]         player_sample,
  output logic [15:0]         env_sample,
  output logic [LVL_BITS-1:0] env_level,
  output logic [2:0]          env_state,
  output logic                out_valid
);

  localparam int unsigned         DIV_W    = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(MCLK_DIV - 1);
  localparam logic [LVL_BITS-1:0] LVL_FULL = '1;
  localparam logic [LVL_BITS:0]   LVL_MAX  = {1'b0, LVL_FULL};

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [DIV_W-1:0]      r_div;
  logic                  w_tick;
  logic [LVL_BITS-1:0]   r_level, w_level_nxt;
  logic [LVL_BITS:0]     w_att_sum, w_dec_diff, w_rel_diff;
  logic [LVL_BITS+16:0]  w_prod;
  logic [15:0]           r_env_sample;
  logic                  r_out_valid;
  logic                  w_unused_prod;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // One extra bit exposes overflow (attack) and borrow (decay/release).
  assign w_att_sum  = {1'b0, r_level} + {1'b0, attack_step};
  assign w_dec_diff = {1'b0, r_level} - {1'b0, decay_step};
  assign w_rel_diff = {1'b0, r_level} - {1'b0, release_step};

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    if (w_tick) begin
      unique case (r_state)
        StIdle: begin
          if (gate) w_state_nxt = StAttack;
        end
        StAttack: begin
          if (!gate) begin
            w_state_nxt = StRelease;
          end else if (attack_step == '0 || w_att_sum >= LVL_MAX) begin
            w_state_nxt = StDecay;
            w_level_nxt = LVL_FULL;
          end else begin
            w_level_nxt = w_att_sum[LVL_BITS-1:0];
          end
        end
        StDecay: begin
          if (!gate) begin
            w_state_nxt = StRelease;
          end else if (decay_step == '0 || w_dec_diff[LVL_BITS] ||
                       w_dec_diff <= {1'b0, sustain_level}) begin
            w_state_nxt = StSustain;
            w_level_nxt = sustain_level;
          end else begin
            w_level_nxt = w_dec_diff[LVL_BITS-1:0];
          end
        end
        StSustain: begin
          if (!gate) w_state_nxt = StRelease;
          else       w_level_nxt = sustain_level;
        end
        StRelease: begin
          if (gate) begin
            w_state_nxt = StAttack;
          end else if (release_step == '0 || w_rel_diff[LVL_BITS] || w_rel_diff == '0) begin
            w_state_nxt = StIdle;
            w_level_nxt = '0;
          end else begin
            w_level_nxt = w_rel_diff[LVL_BITS-1:0];
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_level_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_level <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Low bits of a signed*unsigned product are sign-agnostic, so a plain multiply of the
  // sign-extended operands yields the signed result; the slice is the floor shift by LVL_BITS.
  assign w_prod = {{(LVL_BITS + 1){player_sample[15]}}, player_sample} *
                  {17'b0, w_level_nxt};
  assign w_unused_prod = ^{w_prod[LVL_BITS+16], w_prod[LVL_BITS-1:0]};

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_env_sample <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_out_valid <= w_tick;
      if (w_tick) r_env_sample <= w_prod[LVL_BITS+15:LVL_BITS];
    end
  end

  assign env_sample = r_env_sample;
  assign env_level  = r_level;
  assign env_state  = r_state;
  assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed self-checking bench for adsr_envelope with hand-computed levels and samples.
module tb_adsr_envelope;

  localparam int unsigned DIV = 16;
  localparam int unsigned LB  = 16;

  logic          mclk = 1'b0;
  logic          rst  = 1'b1;
  logic          gate = 1'b0;
  logic [LB-1:0] attack_step   = '0;
  logic [LB-1:0] decay_step    = '0;
  logic [LB-1:0] sustain_level = '0;
  logic [LB-1:0] release_step  = '0;
  logic [15:0]   player_sample = '0;
  logic [15:0]   env_sample;
  logic [LB-1:0] env_level;
  logic [2:0]    env_state;
  logic          out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  adsr_envelope #(.MCLK_DIV(DIV), .LVL_BITS(LB)) dut (
    .mclk          (mclk),
    .rst           (rst),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .player_sample (player_sample),
    .env_sample    (env_sample),
    .env_level     (env_level),
    .env_state     (env_state),
    .out_valid     (out_valid)
  );

  always #5 mclk = ~mclk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Returns at the negedge where out_valid is seen high.
  task automatic next_tick(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 2 * DIV && !seen; k++) begin
      @(negedge mclk);
      if (out_valid) seen = 1'b1;
    end
    check_eq({tag, " tick"}, 32'(seen), 32'd1);
  endtask

  task automatic tick_sl(input string tag, input logic [2:0] st, input logic [15:0] lvl);
    next_tick(tag);
    check_eq({tag, " state"}, 32'(env_state), 32'(st));
    check_eq({tag, " level"}, 32'(env_level), 32'(lvl));
  endtask

  initial begin
    int cnt;
    logic [15:0] dlvl;
    player_sample = 16'h4000;
    repeat (3) @(negedge mclk);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst state", 32'(env_state), 32'd0);
    check_eq("rst level", 32'(env_level), 32'd0);
    check_eq("rst sample", 32'(env_sample), 32'd0);
    rst = 1'b0;

    // Test 1: idle cadence
    cnt = 0;
    while (!out_valid && cnt < 3 * DIV) begin
      @(negedge mclk);
      cnt++;
    end
    check_eq("first tick latency", 32'(cnt), 32'(DIV));
    @(negedge mclk);
    check_eq("valid pulse width", 32'(out_valid), 32'd0);
    cnt = 1;
    while (!out_valid && cnt < 3 * DIV) begin
      @(negedge mclk);
      cnt++;
    end
    check_eq("tick period", 32'(cnt), 32'(DIV));
    check_eq("idle sample", 32'(env_sample), 32'd0);
    check_eq("idle state", 32'(env_state), 32'd0);

    // Test 2/3: full ADSR with scaling checks
    attack_step = 16'h4000; decay_step = 16'h1000;
    sustain_level = 16'h8000; release_step = 16'h2000;
    player_sample = 16'h7FFF; gate = 1'b1;
    tick_sl("atk0", 3'd1, 16'h0000);
    check_eq("atk0 sample", 32'(env_sample), 32'h0000);
    tick_sl("atk1", 3'd1, 16'h4000);
    check_eq("atk1 sample", 32'(env_sample), 32'h1FFF);
    tick_sl("atk2", 3'd1, 16'h8000);
    check_eq("atk2 sample", 32'(env_sample), 32'h3FFF);
    tick_sl("atk3", 3'd1, 16'hC000);
    check_eq("atk3 sample", 32'(env_sample), 32'h5FFF);
    tick_sl("dec max", 3'd2, 16'hFFFF);
    check_eq("max sample", 32'(env_sample), 32'h7FFE);
    for (int k = 1; k <= 7; k++) begin
      dlvl = 16'hFFFF - 16'(k * 16'h1000);
      tick_sl("decay", 3'd2, dlvl);
    end
    tick_sl("sus", 3'd3, 16'h8000);
    check_eq("half scale sample", 32'(env_sample), 32'h3FFF);
    player_sample = 16'hFFFE;
    tick_sl("sus neg", 3'd3, 16'h8000);
    check_eq("neg half sample", 32'(env_sample), 32'hFFFF);
    sustain_level = 16'h9000;
    tick_sl("sus track", 3'd3, 16'h9000);
    check_eq("neg floor sample", 32'(env_sample), 32'hFFFE);
    sustain_level = 16'h8000; player_sample = 16'h7FFF;
    tick_sl("sus back", 3'd3, 16'h8000);
    gate = 1'b0;
    tick_sl("rel enter", 3'd4, 16'h8000);
    tick_sl("rel1", 3'd4, 16'h6000);
    tick_sl("rel2", 3'd4, 16'h4000);
    tick_sl("rel3", 3'd4, 16'h2000);
    tick_sl("rel idle", 3'd0, 16'h0000);
    check_eq("rel idle sample", 32'(env_sample), 32'h0000);

    // Test 4: retrigger during release keeps level
    player_sample = 16'h1000; gate = 1'b1;
    tick_sl("rt atk0", 3'd1, 16'h0000);
    tick_sl("rt atk1", 3'd1, 16'h4000);
    tick_sl("rt atk2", 3'd1, 16'h8000);
    tick_sl("rt atk3", 3'd1, 16'hC000);
    gate = 1'b0;
    tick_sl("rt rel0", 3'd4, 16'hC000);
    tick_sl("rt rel1", 3'd4, 16'hA000);
    gate = 1'b1;
    tick_sl("rt retrig", 3'd1, 16'hA000);
    check_eq("rt sample", 32'(env_sample), 32'h0A00);
    tick_sl("rt atk4", 3'd1, 16'hE000);
    tick_sl("rt dec", 3'd2, 16'hFFFF);
    gate = 1'b0; release_step = 16'h0000;
    tick_sl("rt rel", 3'd4, 16'hFFFF);
    tick_sl("rt zero rel", 3'd0, 16'h0000);

    // Test 5: zero steps
    attack_step = '0; decay_step = '0; release_step = '0; gate = 1'b1;
    tick_sl("z atk", 3'd1, 16'h0000);
    tick_sl("z dec", 3'd2, 16'hFFFF);
    tick_sl("z sus", 3'd3, 16'h8000);
    gate = 1'b0;
    tick_sl("z rel", 3'd4, 16'h8000);
    tick_sl("z idle", 3'd0, 16'h0000);

    // Test 6: short gate pulse between ticks
    repeat (2) @(negedge mclk);
    gate = 1'b1;
    repeat (4) @(negedge mclk);
    gate = 1'b0;
    tick_sl("short gate", 3'd0, 16'h0000);

    // Asynchronous reset mid-note
    attack_step = 16'h4000; player_sample = 16'h7FFF; gate = 1'b1;
    tick_sl("mr atk0", 3'd1, 16'h0000);
    tick_sl("mr atk1", 3'd1, 16'h4000);
    repeat (3) @(negedge mclk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid rst state", 32'(env_state), 32'd0);
    check_eq("mid rst level", 32'(env_level), 32'd0);
    check_eq("mid rst sample", 32'(env_sample), 32'd0);
    check_eq("mid rst valid", 32'(out_valid), 32'd0);
    @(negedge mclk);
    rst = 1'b0;
    tick_sl("post rst", 3'd1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
